// File: rtl/coin_input_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// coin_input_conditioner : sync + debounce of three coin buttons, one-coin
// arbiter emitting single-cycle active-low pulses.           Rev 1.0
// ============================================================================
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn5_n,
  input  logic btn10_n,
  input  logic btn20_n,
  input  logic inhibit,
  output logic c5,
  output logic c10,
  output logic c20,
  output logic busy,
  output logic coin_rejected
);

  localparam int c_DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_HW = (HOLDOFF_CYCLES < 1) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [c_DW-1:0] c_DB_LAST   = c_DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_HW-1:0] c_HOLD_LOAD = c_HW'(HOLDOFF_CYCLES);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_PULSE   = 2'd1;
  localparam logic [1:0] c_HOLDOFF = 2'd2;

  logic [2:0] w_raw_n;
  logic [2:0] w_press;
  logic [1:0] r_warm;
  logic       w_warm;

  assign w_raw_n = {btn20_n, btn10_n, btn5_n};
  assign w_warm  = (r_warm == 2'd2);

  // Synchronizers refill two cycles after reset; until then their reset value
  // would hide a button that is still held down.
  always_ff @(posedge clk) begin
    if (rst)
      r_warm <= 2'd0;
    else if (!w_warm)
      r_warm <= r_warm + 2'd1;
  end

  generate
    for (genvar i = 0; i < 3; i++) begin : g_chan
      logic            r_sync1;
      logic            r_sync2;
      logic            r_stable;
      logic            r_stable_d;
      logic            r_armed;
      logic [c_DW-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync1    <= 1'b1;
          r_sync2    <= 1'b1;
          r_stable   <= 1'b1;
          r_stable_d <= 1'b1;
          r_armed    <= 1'b0;
          r_cnt      <= '0;
        end else begin
          r_sync1    <= w_raw_n[i];
          r_sync2    <= r_sync1;
          r_stable_d <= r_stable;
          if (r_sync2 == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + c_DW'(1);
          end
          // A button held through reset must be seen released before it counts.
          if (w_warm && r_stable && r_sync2)
            r_armed <= 1'b1;
        end
      end

      assign w_press[i] = r_armed & r_stable_d & ~r_stable;
    end
  endgenerate

  logic [1:0]      r_state;
  logic [c_HW-1:0] r_hold;
  logic [2:0]      r_coin_n;
  logic            r_rej;
  logic            w_any;
  logic            w_multi;
  logic [2:0]      w_grant_n;

  assign w_any   = |w_press;
  assign w_multi = (w_press[0] & w_press[1]) | (w_press[0] & w_press[2]) |
                   (w_press[1] & w_press[2]);

  always_comb begin
    w_grant_n = 3'b111;
    if (w_press[0])      w_grant_n = 3'b110;
    else if (w_press[1]) w_grant_n = 3'b101;
    else if (w_press[2]) w_grant_n = 3'b011;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_hold   <= '0;
      r_coin_n <= 3'b111;
      r_rej    <= 1'b0;
    end else begin
      r_coin_n <= 3'b111;
      r_rej    <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_any) begin
            if (inhibit) begin
              r_rej <= 1'b1;
            end else begin
              r_coin_n <= w_grant_n;
              r_rej    <= w_multi;
              r_state  <= c_PULSE;
            end
          end
        end
        c_PULSE: begin
          r_rej <= w_any;
          if (HOLDOFF_CYCLES == 0) begin
            r_state <= c_IDLE;
          end else begin
            r_state <= c_HOLDOFF;
            r_hold  <= c_HOLD_LOAD;
          end
        end
        c_HOLDOFF: begin
          r_rej <= w_any;
          if (r_hold == c_HW'(1))
            r_state <= c_IDLE;
          else
            r_hold <= r_hold - c_HW'(1);
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign c5            = r_coin_n[0];
  assign c10           = r_coin_n[1];
  assign c20           = r_coin_n[2];
  assign busy          = (r_state == c_PULSE) || (r_state == c_HOLDOFF);
  assign coin_rejected = r_rej;

endmodule
`default_nettype wire

// File: tb/tb_coin_input_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_coin_input_conditioner : directed stimulus with queued expected pulses.
// Rev 1.0
// ============================================================================
module tb_coin_input_conditioner;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic btn5_n  = 1'b1;
  logic btn10_n = 1'b1;
  logic btn20_n = 1'b1;
  logic inhibit = 1'b0;
  logic c5, c10, c20, busy, coin_rejected;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int   cyc;
    logic c5;
    logic c10;
    logic c20;
    logic rej;
  } exp_t;

  exp_t exp_q[$];

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn5_n       (btn5_n),
    .btn10_n      (btn10_n),
    .btn20_n      (btn20_n),
    .inhibit      (inhibit),
    .c5           (c5),
    .c10          (c10),
    .c20          (c20),
    .busy         (busy),
    .coin_rejected(coin_rejected)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push(input int c, input logic e5, input logic e10,
                      input logic e20, input logic er);
    exp_t e;
    e.cyc = c; e.c5 = e5; e.c10 = e10; e.c20 = e20; e.rej = er;
    exp_q.push_back(e);
  endtask

  // Monitor: any active output must match the next queued expectation.
  always @(negedge clk) begin : monitor
    exp_t got;
    exp_t want;
    if (!c5 || !c10 || !c20 || coin_rejected) begin
      got.cyc = cyc; got.c5 = c5; got.c10 = c10; got.c20 = c20; got.rej = coin_rejected;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got c5=%b c10=%b c20=%b rej=%b at cycle %0d, required no activity",
                 c5, c10, c20, coin_rejected, cyc);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL coin_event: got cyc=%0d c5=%b c10=%b c20=%b rej=%b required cyc=%0d c5=%b c10=%b c20=%b rej=%b",
                   got.cyc, got.c5, got.c10, got.c20, got.rej,
                   want.cyc, want.c5, want.c10, want.c20, want.rej);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    step(3);
    @(negedge clk);
    check("reset_c5", c5, 1);
    check("reset_c10", c10, 1);
    check("reset_c20", c20, 1);
    check("reset_busy", busy, 0);
    check("reset_rej", coin_rejected, 0);
    step(1);
    rst = 1'b0;
    step(6);

    // Clean btn10 press, busy window of 1 + 8 cycles
    btn10_n = 1'b0; n = cyc + 1;
    push(n + 6, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_cyc(n + 5); check("t1_busy_pre", busy, 0);
    for (int k = 6; k <= 14; k++) begin
      wait_cyc(n + k); check("t1_busy", busy, 1);
    end
    wait_cyc(n + 15); check("t1_busy_post", busy, 0);
    step(5);
    btn10_n = 1'b1;
    step(20);

    // Bouncing btn5, then held
    btn5_n = 1'b0; step(2);
    btn5_n = 1'b1; step(1);
    btn5_n = 1'b0; step(3);
    btn5_n = 1'b1; step(1);
    btn5_n = 1'b0; n = cyc + 1;
    push(n + 6, 1'b0, 1'b1, 1'b1, 1'b0);
    step(20);
    btn5_n = 1'b1;
    step(20);

    // Simultaneous btn5 + btn20: c5 wins, one rejection alongside
    btn5_n = 1'b0; btn20_n = 1'b0; n = cyc + 1;
    push(n + 6, 1'b0, 1'b1, 1'b1, 1'b1);
    step(20);
    btn5_n = 1'b1; btn20_n = 1'b1;
    step(20);

    // btn20 debounced 3 cycles into HOLDOFF after a btn10 coin
    btn10_n = 1'b0; n = cyc + 1;
    push(n + 6, 1'b1, 1'b0, 1'b1, 1'b0);
    push(n + 10, 1'b1, 1'b1, 1'b1, 1'b1);
    step(4);
    btn20_n = 1'b0;
    wait_cyc(n + 14); check("t4_busy_last", busy, 1);
    wait_cyc(n + 15); check("t4_busy_idle", busy, 0);
    step(10);
    btn10_n = 1'b1; btn20_n = 1'b1;
    step(20);

    // Inhibited press rejected, then accepted once inhibit drops
    inhibit = 1'b1; btn20_n = 1'b0; n = cyc + 1;
    push(n + 6, 1'b1, 1'b1, 1'b1, 1'b1);
    step(20);
    btn20_n = 1'b1;
    step(20);
    inhibit = 1'b0;
    step(2);
    btn20_n = 1'b0; n = cyc + 1;
    push(n + 6, 1'b1, 1'b1, 1'b0, 1'b0);
    step(20);
    btn20_n = 1'b1;
    step(20);

    // Reset during the c10 pulse; held button must not re-fire
    btn10_n = 1'b0; n = cyc + 1;
    push(n + 6, 1'b1, 1'b0, 1'b1, 1'b0);
    step(7);
    rst = 1'b1;
    wait_cyc(n + 7);
    check("t6_c10_after_rst", c10, 1);
    check("t6_busy_after_rst", busy, 0);
    step(1);
    rst = 1'b0;
    step(30);
    btn10_n = 1'b1;
    step(20);
    btn10_n = 1'b0; n = cyc + 1;
    push(n + 6, 1'b1, 1'b0, 1'b1, 1'b0);
    step(20);
    btn10_n = 1'b1;
    step(20);

    check("pending_expected", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coin_input_conditioner.md
Name: coin_input_conditioner

Overview:
- Front-end stage for the chocolate machine coin FSM.
- Takes raw, bouncing, asynchronous active-low coin buttons and synchronizes and debounces each one.
- Converts each press into exactly one single-cycle active-low pulse on c5/c10/c20, which drive the coin FSM's coin inputs directly.
- Enforces one coin per accept window with priority arbitration and a holdoff, so the FSM never sees overlapping or repeated coins.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a level change (>=1).
- HOLDOFF_CYCLES, 8, idle cycles enforced after each emitted coin pulse (>=0).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- btn5_n  input  1  raw 5-cent button, active-low, asynchronous.
- btn10_n  input  1  raw 10-cent button, active-low, asynchronous.
- btn20_n  input  1  raw 20-cent button, active-low, asynchronous.
- inhibit  input  1  active-high; while high, new presses are rejected (vend in progress).
- c5  output  1  active-low one-cycle coin pulse to coin FSM; idle high.
- c10  output  1  active-low one-cycle coin pulse; idle high.
- c20  output  1  active-low one-cycle coin pulse; idle high.
- busy  output  1  high while the arbiter is in PULSE or HOLDOFF.
- coin_rejected  output  1  active-high one-cycle pulse when a debounced press is discarded.

Behaviour:
- Reset values: sync flops = 1, debounced state = 1 (released), counters = 0, FSM = IDLE, c5/c10/c20 = 1, busy = 0, coin_rejected = 0.
- A reset asserted mid-pulse or mid-holdoff returns all of the above to reset values at that edge.
- Synchronizer: two flops per channel; s = second stage.
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - If s == stable, counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1, stable <= s and counter <= 0.
  - Else counter++.
  - Any bounce back to the stable value restarts the count.
- Press event: the cycle in which stable transitions 1->0. Release (0->1) is debounced identically but generates no event.
- Holding a button produces one event only; no auto-repeat.
- Latency: raw held low and first sampled at edge N -> stable flips at edge N+1+DEBOUNCE_CYCLES -> coin output low for exactly the one cycle following edge N+2+DEBOUNCE_CYCLES.
- Arbiter FSM states: IDLE, PULSE, HOLDOFF.
  - IDLE, inhibit=0, >=1 event: accept one coin by priority c5 > c10 > c20 (same priority order as the coin FSM). Drive the matching output low next cycle and go to PULSE. Any other simultaneous events are discarded, with a single coin_rejected pulse.
  - IDLE, inhibit=1, event(s): all discarded; coin_rejected pulses for one cycle; stay IDLE.
  - PULSE: lasts exactly 1 cycle. Then go to HOLDOFF with holdoff counter loaded to HOLDOFF_CYCLES, or go straight to IDLE if HOLDOFF_CYCLES=0.
  - HOLDOFF: decrement each cycle; go to IDLE when count reaches 1 (stays exactly HOLDOFF_CYCLES cycles).
  - Any event arriving in PULSE or HOLDOFF: discarded, coin_rejected pulses. Events are never queued.
- Outputs are registered: at most one of c5/c10/c20 low in any cycle. busy=1 in PULSE and HOLDOFF.
- coin_rejected is registered, aligned to the cycle after the discarded event.
- inhibit is sampled synchronously and does not affect an already accepted pulse.

Test Plan:
- Reset, then clean press of btn10_n held 20 cycles (DEBOUNCE_CYCLES=4), first sampled at edge N -> c10 low only in the cycle after edge N+6; c5/c20 stay high; busy high for 1+8 cycles; no second pulse on release.
- btn5_n bounces (low 2 cycles, high 1, low 3, high 1) then held low -> no pulse during bounce; exactly one c5 pulse, 6 cycles after the final stable low run begins; coin_rejected stays 0.
- btn5_n and btn20_n released-to-pressed on the same edge -> one c5 pulse, no c20 pulse, one coin_rejected pulse in the same cycle as c5.
- btn10_n press accepted, btn20_n press debounced 3 cycles into HOLDOFF -> c20 never pulses, coin_rejected pulses once, FSM returns to IDLE 8 cycles after PULSE.
- inhibit=1 while btn20_n is pressed -> no coin pulse, coin_rejected once. Press again after inhibit=0 -> c20 pulses once.
- rst asserted in the PULSE cycle of c10 -> c10 high at the next edge; busy=0; a held button produces no event until it is released and pressed again.
